// File: rtl/div_clock_monitor.sv
// div_clock_monitor: watches a divided clock (clk_in, sampled as data in the
// clk domain) and produces edge strobes, a rise-to-rise period measurement,
// a lock indication and a sticky error flag for loss of lock.
//
// Ports:
//   clk         in   1      system clock, all logic on posedge
//   reset       in   1      synchronous, active-high
//   clk_in      in   1      divided clock, synchronous to clk
//   err_clr     in   1      one-cycle pulse that clears err
//   rise_pulse  out  1      one-cycle strobe per clk_in 0->1
//   fall_pulse  out  1      one-cycle strobe per clk_in 1->0
//   period      out  CNT_W  last measured rise-to-rise period, in clk cycles
//   locked      out  1      LOCK_PERIODS consecutive periods equal to DIV
//   err         out  1      sticky loss-of-lock flag (mismatch or stall)
module div_clock_monitor #(
    parameter int unsigned DIV          = 4,
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned LOCK_PERIODS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_in,
    input  logic             err_clr,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] period,
    output logic             locked,
    output logic             err
);

    localparam int unsigned GOOD_W = (LOCK_PERIODS < 2) ? 1 : $clog2(LOCK_PERIODS + 1);

    localparam logic [CNT_W-1:0]  DIV_V    = CNT_W'(DIV);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(2 * DIV);
    localparam logic [GOOD_W-1:0] GOOD_TGT = GOOD_W'(LOCK_PERIODS);

    typedef enum logic [1:0] {
        SEEK    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t              state;
    logic                s_q;
    logic [CNT_W-1:0]    cnt;
    logic [GOOD_W-1:0]   good_cnt;

    logic                rise_det;
    logic                fall_det;
    logic                timeout;
    logic                period_ok;
    logic                err_set;
    logic [GOOD_W-1:0]   good_nxt;

    // Edge detection against the previous sample of clk_in
    assign rise_det  = clk_in & ~s_q;
    assign fall_det  = ~clk_in & s_q;

    // A stall is a saturated counter with no rise arriving this cycle
    assign timeout   = (cnt == CNT_MAX) & ~rise_det;
    assign period_ok = (cnt == DIV_V);
    assign good_nxt  = good_cnt + GOOD_W'(1);

    // Loss of lock is only flagged while locked
    assign err_set   = (state == LOCKED) & ((rise_det & ~period_ok) | timeout);

    // Edge strobes, period counter, lock FSM and sticky error
    always_ff @(posedge clk) begin
        if (reset) begin
            s_q        <= 1'b1;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            cnt        <= '0;
            period     <= '0;
            good_cnt   <= '0;
            state      <= SEEK;
            locked     <= 1'b0;
            err        <= 1'b0;
        end else begin
            s_q        <= clk_in;
            rise_pulse <= rise_det;
            fall_pulse <= fall_det;

            if (rise_det) begin
                cnt <= CNT_W'(1);
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end

            // The first rise out of SEEK closes no complete period
            if (rise_det && (state != SEEK)) begin
                period <= cnt;
            end

            // Setting wins over a simultaneous clear
            err <= err_set | (err & ~err_clr);

            case (state)
                SEEK: begin
                    if (rise_det) begin
                        state    <= MEASURE;
                        good_cnt <= '0;
                    end
                end
                MEASURE: begin
                    if (rise_det) begin
                        if (period_ok) begin
                            good_cnt <= good_nxt;
                            if (good_nxt == GOOD_TGT) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else begin
                            good_cnt <= '0;
                        end
                    end else if (timeout) begin
                        state    <= SEEK;
                        good_cnt <= '0;
                    end
                end
                LOCKED: begin
                    if (rise_det) begin
                        if (!period_ok) begin
                            state    <= MEASURE;
                            locked   <= 1'b0;
                            good_cnt <= '0;
                        end
                    end else if (timeout) begin
                        state    <= SEEK;
                        locked   <= 1'b0;
                        good_cnt <= '0;
                    end
                end
                default: begin
                    state    <= SEEK;
                    locked   <= 1'b0;
                    good_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_clock_monitor.sv
// Directed, table-driven bench for div_clock_monitor (DIV=4, LOCK_PERIODS=4).
// Each record holds the inputs for one clk edge and the outputs expected
// just after that edge.
module tb_div_clock_monitor;

    localparam int unsigned CNT_W = 8;

    logic             clk;
    logic             reset;
    logic             clk_in;
    logic             err_clr;
    logic             rise_pulse;
    logic             fall_pulse;
    logic [CNT_W-1:0] period;
    logic             locked;
    logic             err;

    div_clock_monitor #(
        .DIV          (4),
        .CNT_W        (CNT_W),
        .LOCK_PERIODS (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clk_in     (clk_in),
        .err_clr    (err_clr),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .period     (period),
        .locked     (locked),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             rst;
        logic             x;
        logic             clr;
        logic             r;
        logic             f;
        logic [CNT_W-1:0] p;
        logic             l;
        logic             e;
        string            tag;
    } vec_t;

    vec_t vecs[$];
    int   n_vec;
    int   n_bad;
    logic done;

    task automatic push(input logic rst, input logic x, input logic clr,
                        input logic r, input logic f, input int p,
                        input logic l, input logic e, input string tag);
        vec_t v;
        v.rst = rst; v.x = x; v.clr = clr;
        v.r = r; v.f = f; v.p = CNT_W'(p); v.l = l; v.e = e; v.tag = tag;
        vecs.push_back(v);
    endtask

    // One clean period of 4: high, high, low, low. Period/locked/err only
    // change at the rise, so they are constant across the four cycles.
    // clr pulses err_clr on the rise cycle; e is err after that edge.
    task automatic period4(input int p, input logic l, input logic e,
                           input logic clr, input string tag);
        push(1'b0, 1'b1, clr,  1'b1, 1'b0, p, l, e, {tag, "_rise"});
        push(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, p, l, e, {tag, "_hi"});
        push(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, p, l, e, {tag, "_fall"});
        push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, p, l, e, {tag, "_lo"});
    endtask

    // Watchdog: the run must complete within a bounded time
    initial begin
        done = 1'b0;
        #200000;
        if (!done) begin
            n_bad++;
            $display("FAIL watchdog: simulation did not complete in time");
            $finish;
        end
    end

    initial begin
        n_vec   = 0;
        n_bad   = 0;
        reset   = 1'b1;
        clk_in  = 1'b0;
        err_clr = 1'b0;

        // Reset with clk_in low; s_q resets high so the first low is a fall
        push(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, "reset_state");
        push(1'b0, 1'b0, 1'b0, 0, 1, 0, 0, 0, "t1_first_low");
        push(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, "t1_low2");
        // 1st rise from SEEK keeps period 0; lock on the 5th rise
        period4(0, 0, 0, 0, "t1_p1");
        period4(4, 0, 0, 0, "t1_p2");
        period4(4, 0, 0, 0, "t1_p3");
        period4(4, 0, 0, 0, "t1_p4");
        period4(4, 1, 0, 0, "t1_p5_lock");

        // One 5-cycle period while locked, then relock in 4 good periods
        push(1'b0, 1'b0, 1'b0, 0, 0, 4, 1, 0, "t3_extra_low");
        period4(5, 0, 1, 0, "t3_bad");
        period4(4, 0, 1, 0, "t3_g1");
        period4(4, 0, 1, 0, "t3_g2");
        period4(4, 0, 1, 0, "t3_g3");
        period4(4, 1, 1, 0, "t3_relock");

        // err_clr alone clears; err_clr with a new mismatch leaves err set
        period4(4, 1, 0, 1, "t5_clear");
        push(1'b0, 1'b0, 1'b0, 0, 0, 4, 1, 0, "t5_extra_low");
        period4(5, 0, 1, 1, "t5_set_wins");
        period4(4, 0, 0, 1, "t5_clear_measure");
        period4(4, 0, 0, 0, "t5_g2");
        period4(4, 0, 0, 0, "t5_g3");
        period4(4, 1, 0, 0, "t5_relock");

        // Stuck low: timeout 8 cycles after the last rise, period holds
        push(1'b0, 1'b0, 1'b0, 0, 0, 4, 1, 0, "t4_stall5");
        push(1'b0, 1'b0, 1'b0, 0, 0, 4, 1, 0, "t4_stall6");
        push(1'b0, 1'b0, 1'b0, 0, 0, 4, 1, 0, "t4_stall7");
        push(1'b0, 1'b0, 1'b0, 0, 0, 4, 1, 0, "t4_stall8");
        push(1'b0, 1'b0, 1'b0, 0, 0, 4, 0, 1, "t4_timeout");
        push(1'b0, 1'b0, 1'b0, 0, 0, 4, 0, 1, "t4_seek_hold1");
        push(1'b0, 1'b0, 1'b0, 0, 0, 4, 0, 1, "t4_seek_hold2");
        period4(4, 0, 1, 0, "t4_seek_rise");

        // clk_in high across reset release: no rise until a real 0->1
        push(1'b1, 1'b1, 1'b0, 0, 0, 0, 0, 0, "t2_reset_high");
        push(1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 0, "t2_no_rise");
        push(1'b0, 1'b0, 1'b0, 0, 1, 0, 0, 0, "t2_fall");
        push(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, "t2_low");
        push(1'b0, 1'b1, 1'b0, 1, 0, 0, 0, 0, "t2_rise");
        push(1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 0, "t2_hi");
        push(1'b0, 1'b0, 1'b0, 0, 1, 0, 0, 0, "t2_fall2");
        push(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, "t2_low2");
        period4(4, 0, 0, 0, "t2_g1");
        period4(4, 0, 0, 0, "t2_g2");
        period4(4, 0, 0, 0, "t2_g3");
        period4(4, 1, 0, 0, "t2_lock");

        // Build up err while locked, then reset in the middle of a high phase
        push(1'b0, 1'b0, 1'b0, 0, 0, 4, 1, 0, "t6_extra_low");
        period4(5, 0, 1, 0, "t6_bad");
        period4(4, 0, 1, 0, "t6_g1");
        period4(4, 0, 1, 0, "t6_g2");
        period4(4, 0, 1, 0, "t6_g3");
        push(1'b0, 1'b1, 1'b0, 1, 0, 4, 1, 1, "t6_relock_rise");
        push(1'b1, 1'b1, 1'b0, 0, 0, 0, 0, 0, "t6_reset");
        push(1'b0, 1'b0, 1'b0, 0, 1, 0, 0, 0, "t6_fall");
        push(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, "t6_low");
        period4(0, 0, 0, 0, "t6_r1_seek");
        period4(4, 0, 0, 0, "t6_r2");
        period4(4, 0, 0, 0, "t6_r3");
        period4(4, 0, 0, 0, "t6_r4");
        period4(4, 1, 0, 0, "t6_r5_lock");

        // Standalone reset-state check before the vector table
        reset   = 1'b1;
        clk_in  = 1'b0;
        err_clr = 1'b0;
        @(posedge clk);
        #1;
        if (rise_pulse !== 1'b0 || fall_pulse !== 1'b0 || period !== '0 ||
            locked !== 1'b0 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset check: rise=%b fall=%b period=%0d locked=%b err=%b",
                     rise_pulse, fall_pulse, period, locked, err);
        end
        #2;

        foreach (vecs[i]) begin
            reset   = vecs[i].rst;
            clk_in  = vecs[i].x;
            err_clr = vecs[i].clr;
            @(posedge clk);
            #1;
            n_vec++;
            if (rise_pulse !== vecs[i].r || fall_pulse !== vecs[i].f ||
                period !== vecs[i].p || locked !== vecs[i].l || err !== vecs[i].e) begin
                n_bad++;
                $display("FAIL %s (vec %0d): got rise=%b fall=%b period=%0d locked=%b err=%b, want rise=%b fall=%b period=%0d locked=%b err=%b",
                         vecs[i].tag, i, rise_pulse, fall_pulse, period, locked, err,
                         vecs[i].r, vecs[i].f, vecs[i].p, vecs[i].l, vecs[i].e);
            end
            #2;
        end

        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        if (n_bad == 0) $display("PASS");
        else            $display("FAIL");
        $finish;
    end

endmodule
